nanjing_prg_ctrl: RTL and testbench

- Synchronous register controller for the Nanjing PRG banking and protection logic. Clocked from CPU M2.
- Decodes CPU writes to $5000-$5FFF and sequences the 6-bit PRG bank, VRAM-mode bit, security latch, and strobe/trigger protection state.
- Drives prg_addr[20:15], the vram_a12 mode select, and the $5xxx read-back mux.
- Replaces the asynchronous write-strobe register bank. Sits between the CPU bus pins and the PRG ROM/PPU banking logic.

---
 rtl/nanjing_prg_ctrl.sv | 127 ++++++++++++
 tb/tb_nanjing_prg_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanjing_prg_ctrl.sv
// Nanjing PRG banking / protection register controller.
// Decodes CPU writes to $5000-$5FFF on the falling edge of M2 and holds the
// PRG bank, VRAM mode select, security latch and strobe/trigger state.
// Read-back data for $5xxx is a combinational mux of those registers.
module nanjing_prg_ctrl #(
    parameter logic [5:0] BOOT_BANK = 6'h0F,
    parameter logic [5:0] PROT_BANK = 6'h03,
    parameter logic [7:0] MAGIC_VAL = 8'h06,
    parameter logic [7:0] ID_VAL    = 8'h04,
    parameter logic [7:0] OPEN_VAL  = 8'hDB
) (
    input  logic        m2,
    input  logic        rst,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    output logic [5:0]  prg_bank,
    output logic        vram_mode,
    output logic        trigger,
    output logic        boot
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] security;
    logic [7:0] strobe;

    // Address decode
    logic       sel_5xxx;
    logic       wr;
    logic [1:0] reg_sel;
    logic       wr_5000;
    logic       wr_5100;
    logic       wr_5101;
    logic       wr_5200;
    logic       wr_5300;
    logic       magic_hit;
    logic       boot_exit;

    // Address bits that play no part in decoding; mirrors are intentional.
    logic       unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cpu_addr[11], cpu_addr[7:1]};

    // Decode the CPU bus cycle into at most one register write strobe.
    always_comb begin
        sel_5xxx  = (cpu_addr[15:12] == 4'h5);
        wr        = ~cpu_rw & sel_5xxx;
        reg_sel   = cpu_addr[9:8];
        wr_5000   = wr & (reg_sel == 2'd0);
        wr_5100   = wr & (reg_sel == 2'd1) & ~cpu_addr[0];
        wr_5101   = wr & (reg_sel == 2'd1) &  cpu_addr[0];
        wr_5200   = wr & (reg_sel == 2'd2);
        wr_5300   = wr & (reg_sel == 2'd3);
        magic_hit = wr_5100 & (cpu_data_in == MAGIC_VAL);
        boot_exit = wr_5000 | wr_5200 | magic_hit;
    end

    // Register bank and BOOT/RUN state, all updated on the falling edge of M2.
    always_ff @(negedge m2) begin
        if (rst) begin
            state     <= ST_BOOT;
            prg_bank  <= BOOT_BANK;
            vram_mode <= 1'b0;
            security  <= '0;
            strobe    <= '0;
            trigger   <= 1'b0;
            boot      <= 1'b1;
        end else begin
            // While in BOOT the half of the bank not written by this access
            // stays at BOOT_BANK, so the exit edge leaves a defined bank.
            if (wr_5000) begin
                prg_bank[3:0] <= cpu_data_in[3:0];
                vram_mode     <= cpu_data_in[7];
                if (state == ST_BOOT) begin
                    prg_bank[5:4] <= BOOT_BANK[5:4];
                end
            end

            if (wr_5200) begin
                prg_bank[5:4] <= cpu_data_in[1:0];
                if (state == ST_BOOT) begin
                    prg_bank[3:0] <= BOOT_BANK[3:0];
                end
            end

            if (magic_hit) begin
                prg_bank <= PROT_BANK;
            end

            // Toggle is judged against the strobe value held before this write.
            if (wr_5101) begin
                if ((strobe != 8'h00) && (cpu_data_in == 8'h00)) begin
                    trigger <= ~trigger;
                end
                strobe <= cpu_data_in;
            end

            if (wr_5300) begin
                security <= cpu_data_in;
            end

            if ((state == ST_BOOT) && boot_exit) begin
                state <= ST_RUN;
                boot  <= 1'b0;
            end
        end
    end

    // Read-back mux for $5xxx reads.
    always_comb begin
        cpu_data_oe = cpu_rw & sel_5xxx;
        case (cpu_addr[10:8])
            3'd0:    cpu_data_out = ID_VAL;
            3'd1:    cpu_data_out = security;
            3'd5:    cpu_data_out = security & {8{trigger}};
            3'd7:    cpu_data_out = {2'b00, prg_bank};
            default: cpu_data_out = OPEN_VAL;
        endcase
    end

endmodule

// File: tb/tb_nanjing_prg_ctrl.sv
// Directed self-checking bench for nanjing_prg_ctrl.
// Inputs change just after rising M2; outputs are sampled 1 time unit after
// the falling M2 edge that updates them.
module tb_nanjing_prg_ctrl;

    logic        m2;
    logic        rst;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [5:0]  prg_bank;
    logic        vram_mode;
    logic        trigger;
    logic        boot;

    int errors = 0;
    int checks = 0;

    nanjing_prg_ctrl #(
        .BOOT_BANK (6'h0F),
        .PROT_BANK (6'h03),
        .MAGIC_VAL (8'h06),
        .ID_VAL    (8'h04),
        .OPEN_VAL  (8'hDB)
    ) dut (
        .m2           (m2),
        .rst          (rst),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .prg_bank     (prg_bank),
        .vram_mode    (vram_mode),
        .trigger      (trigger),
        .boot         (boot)
    );

    initial m2 = 1'b1;
    always #10 m2 = ~m2;

    // One CPU write, landing on the next falling M2 edge.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge m2);
        #1;
        cpu_rw      = 1'b0;
        cpu_addr    = a;
        cpu_data_in = d;
        @(negedge m2);
        #1;
        cpu_rw      = 1'b1;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
    endtask

    // Combinational read-back; no clock edge involved.
    task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        cpu_rw   = 1'b1;
        cpu_addr = a;
        #1;
        d  = cpu_data_out;
        oe = cpu_data_oe;
        cpu_addr = 16'h0000;
    endtask

    task automatic apply_reset();
        @(posedge m2);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge m2);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        apply_reset();
        checks++; if (prg_bank !== 6'h0F) begin errors++; $display("FAIL reset_bank got=%h exp=%h", prg_bank, 6'h0F); end
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL reset_boot got=%b exp=1", boot); end
        checks++; if (vram_mode !== 1'b0) begin errors++; $display("FAIL reset_vram got=%b exp=0", vram_mode); end
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", trigger); end
        do_read(16'h5700, d, oe);
        checks++; if (d !== 8'h0F) begin errors++; $display("FAIL reset_rd5700 got=%h exp=0f", d); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL reset_oe5700 got=%b exp=1", oe); end
        do_read(16'h5000, d, oe);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_rd5000 got=%h exp=04", d); end
        do_read(16'h5400, d, oe);
        checks++; if (d !== 8'hDB) begin errors++; $display("FAIL reset_rd5400 got=%h exp=db", d); end
        do_read(16'h5100, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rd5100 got=%h exp=00", d); end
    endtask

    task automatic test_boot_exit();
        logic [7:0] d;
        logic       oe;
        do_write(16'h5000, 8'h85);
        checks++; if (prg_bank !== 6'h05) begin errors++; $display("FAIL exit_bank got=%h exp=05", prg_bank); end
        checks++; if (vram_mode !== 1'b1) begin errors++; $display("FAIL exit_vram got=%b exp=1", vram_mode); end
        checks++; if (boot !== 1'b0) begin errors++; $display("FAIL exit_boot got=%b exp=0", boot); end
        do_write(16'h5200, 8'h02);
        checks++; if (prg_bank !== 6'h25) begin errors++; $display("FAIL exit_bank_hi got=%h exp=25", prg_bank); end
        do_read(16'h5700, d, oe);
        checks++; if (d !== 8'h25) begin errors++; $display("FAIL exit_rd5700 got=%h exp=25", d); end
    endtask

    task automatic test_magic();
        apply_reset();
        do_write(16'h5100, 8'h07);
        checks++; if (prg_bank !== 6'h0F) begin errors++; $display("FAIL magic_bad_bank got=%h exp=0f", prg_bank); end
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL magic_bad_boot got=%b exp=1", boot); end
        // $5101 and $5300 writes do not leave BOOT either
        do_write(16'h5101, 8'h06);
        do_write(16'h5300, 8'h06);
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL magic_other_boot got=%b exp=1", boot); end
        checks++; if (prg_bank !== 6'h0F) begin errors++; $display("FAIL magic_other_bank got=%h exp=0f", prg_bank); end
        do_write(16'h5100, 8'h06);
        checks++; if (prg_bank !== 6'h03) begin errors++; $display("FAIL magic_ok_bank got=%h exp=03", prg_bank); end
        checks++; if (boot !== 1'b0) begin errors++; $display("FAIL magic_ok_boot got=%b exp=0", boot); end
    endtask

    task automatic test_protection();
        logic [7:0] d;
        logic       oe;
        // strobe currently 0x06 from the BOOT-phase write; clear it without a toggle base
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL prot_pre_toggle got=%b exp=1", trigger); end
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL prot_pre_hold got=%b exp=1", trigger); end
        do_write(16'h5101, 8'h01);
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL prot_pre_clear got=%b exp=0", trigger); end
        // Scenario from trigger=0
        do_write(16'h5300, 8'hA5);
        do_write(16'h5101, 8'h12);
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL prot_nonzero got=%b exp=0", trigger); end
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL prot_toggle got=%b exp=1", trigger); end
        do_read(16'h5500, d, oe);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL prot_rd5500 got=%h exp=a5", d); end
        do_read(16'h5100, d, oe);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL prot_rd5100 got=%h exp=a5", d); end
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL prot_repeat got=%b exp=1", trigger); end
        do_write(16'h5101, 8'h01);
        do_write(16'h5101, 8'h00);
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL prot_untoggle got=%b exp=0", trigger); end
        do_read(16'h5500, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL prot_rd5500_off got=%h exp=00", d); end
        checks++; if (prg_bank !== 6'h03) begin errors++; $display("FAIL prot_bank_kept got=%h exp=03", prg_bank); end
    endtask

    task automatic test_reset_priority();
        @(posedge m2);
        #1;
        rst         = 1'b1;
        cpu_rw      = 1'b0;
        cpu_addr    = 16'h5000;
        cpu_data_in = 8'h83;
        @(negedge m2);
        #1;
        rst         = 1'b0;
        cpu_rw      = 1'b1;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        checks++; if (prg_bank !== 6'h0F) begin errors++; $display("FAIL rstpri_bank got=%h exp=0f", prg_bank); end
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL rstpri_boot got=%b exp=1", boot); end
        checks++; if (vram_mode !== 1'b0) begin errors++; $display("FAIL rstpri_vram got=%b exp=0", vram_mode); end
        do_write(16'h6000, 8'h85);
        do_write(16'h4000, 8'h85);
        do_write(16'h4100, 8'h06);
        checks++; if (prg_bank !== 6'h0F) begin errors++; $display("FAIL outside_bank got=%h exp=0f", prg_bank); end
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL outside_boot got=%b exp=1", boot); end
        checks++; if (vram_mode !== 1'b0) begin errors++; $display("FAIL outside_vram got=%b exp=0", vram_mode); end
        // $5C00 mirrors $5000
        do_write(16'h5C00, 8'h8A);
        checks++; if (prg_bank !== 6'h0A) begin errors++; $display("FAIL mirror_bank got=%h exp=0a", prg_bank); end
        checks++; if (boot !== 1'b0) begin errors++; $display("FAIL mirror_boot got=%b exp=0", boot); end
        // $53FE mirrors $5300
        do_write(16'h53FE, 8'h5C);
    endtask

    task automatic test_read_only();
        logic [7:0] d;
        logic       oe;
        int         oe_bad;
        oe_bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge m2);
            #1;
            cpu_rw      = 1'b1;
            cpu_addr    = 16'h5000 + 16'((i % 8) << 8);
            cpu_data_in = 8'h06;
            #1;
            if (cpu_data_oe !== 1'b1) oe_bad++;
            @(negedge m2);
        end
        #1;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL ro_oe_low got=%0d exp=0", oe_bad); end
        checks++; if (prg_bank !== 6'h0A) begin errors++; $display("FAIL ro_bank got=%h exp=0a", prg_bank); end
        checks++; if (vram_mode !== 1'b1) begin errors++; $display("FAIL ro_vram got=%b exp=1", vram_mode); end
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL ro_trigger got=%b exp=0", trigger); end
        checks++; if (boot !== 1'b0) begin errors++; $display("FAIL ro_boot got=%b exp=0", boot); end
        do_read(16'h5100, d, oe);
        checks++; if (d !== 8'h5C) begin errors++; $display("FAIL ro_security got=%h exp=5c", d); end
        do_read(16'h6000, d, oe);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL oe_6000 got=%b exp=0", oe); end
        do_read(16'h4FFF, d, oe);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL oe_4fff got=%b exp=0", oe); end
        // write cycle: enable must drop (no edge happens in this window)
        cpu_rw   = 1'b0;
        cpu_addr = 16'h5000;
        #1;
        oe = cpu_data_oe;
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0000;
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL oe_write got=%b exp=0", oe); end
    endtask

    task automatic test_back_to_back();
        do_write(16'h5200, 8'h03);
        checks++; if (prg_bank !== 6'h3A) begin errors++; $display("FAIL b2b_hi got=%h exp=3a", prg_bank); end
        do_write(16'h5000, 8'h81);
        checks++; if (prg_bank !== 6'h31) begin errors++; $display("FAIL b2b_first got=%h exp=31", prg_bank); end
        checks++; if (vram_mode !== 1'b1) begin errors++; $display("FAIL b2b_first_vram got=%b exp=1", vram_mode); end
        do_write(16'h5000, 8'h02);
        checks++; if (prg_bank !== 6'h32) begin errors++; $display("FAIL b2b_second got=%h exp=32", prg_bank); end
        checks++; if (vram_mode !== 1'b0) begin errors++; $display("FAIL b2b_second_vram got=%b exp=0", vram_mode); end
        // RUN ignores the magic write's BOOT semantics but still loads PROT_BANK
        do_write(16'h5100, 8'h06);
        checks++; if (prg_bank !== 6'h03) begin errors++; $display("FAIL run_magic got=%h exp=03", prg_bank); end
    endtask

    initial begin
        rst         = 1'b0;
        cpu_rw      = 1'b1;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        test_reset();
        test_boot_exit();
        test_magic();
        test_protection();
        test_reset_priority();
        test_read_only();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
